// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the single-port memory arbiter.
// Build option ARB_RR_EN selects round-robin instead of data-first arbitration.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int DEF_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_port_arbiter_arb_grant_select.sv
// Combinational winner selection between instruction and data requesters.
// ARB_RR_EN defined: alternate on contention using the previous grant; else data wins.
module arb_grant_select
    import mem_port_arbiter_pkg::*;
(
    input  logic       iIReq,
    input  logic       iDReq,
`ifdef ARB_RR_EN
    input  logic [1:0] iLastGrant,
`endif
    output logic [1:0] oWinner
);

    always_comb begin
        oWinner = GNT_NONE;
        if (iIReq && iDReq) begin
`ifdef ARB_RR_EN
            oWinner = (iLastGrant == GNT_D) ? GNT_I : GNT_D;
`else
            oWinner = GNT_D;
`endif
        end else if (iDReq) begin
            oWinner = GNT_D;
        end else if (iIReq) begin
            oWinner = GNT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data buses.
// Optional build macro ARB_RR_EN enables round-robin arbitration on contention.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int CNT_W       = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddress,
    output logic [31:0] oIReadData,
    output logic        oIValid,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic [31:0] oDReadData,
    output logic        oDValid,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [3:0]  oMByteEnable,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    input  logic [31:0] iMReadData,
    output logic [1:0]  oGrant,
    output logic        oBusy,
    output logic [1:0]  oDbgState
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        grant_q;
    logic              write_q;
    logic [3:0]        be_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        winner;

`ifdef ARB_RR_EN
    logic [1:0]        last_grant_q;

    arb_grant_select u_sel (
        .iIReq      (iIReq),
        .iDReq      (iDReq),
        .iLastGrant (last_grant_q),
        .oWinner    (winner)
    );
`else
    arb_grant_select u_sel (
        .iIReq   (iIReq),
        .iDReq   (iDReq),
        .oWinner (winner)
    );
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (winner != GNT_NONE) state_d = ACCESS;
            ACCESS:  if (cnt_q == CNT_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holding registers freeze the winner's request so later input changes are ignored.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            cnt_q   <= '0;
            grant_q <= GNT_NONE;
            write_q <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef ARB_RR_EN
            last_grant_q <= GNT_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (winner != GNT_NONE) begin
                        grant_q <= winner;
                        cnt_q   <= '0;
`ifdef ARB_RR_EN
                        last_grant_q <= winner;
`endif
                        if (winner == GNT_D) begin
                            write_q <= iDWrite;
                            be_q    <= iDByteEnable;
                            addr_q  <= iDAddress;
                            wdata_q <= iDWriteData;
                        end else begin
                            write_q <= 1'b0;
                            be_q    <= 4'hF;
                            addr_q  <= iIAddress;
                            wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) rdata_q <= iMReadData;
                end
                RESP:    grant_q <= GNT_NONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        oIReadData    = '0;
        oIValid       = 1'b0;
        oDReadData    = '0;
        oDValid       = 1'b0;
        oMReadEnable  = 1'b0;
        oMWriteEnable = 1'b0;
        oMByteEnable  = '0;
        oMAddress     = '0;
        oMWriteData   = '0;
        oGrant        = grant_q;
        oBusy         = (state_q != IDLE);
        oDbgState     = state_q;
        case (state_q)
            ACCESS: begin
                oMAddress     = addr_q;
                oMByteEnable  = be_q;
                oMWriteData   = wdata_q;
                oMReadEnable  = !write_q;
                // A store is issued once only so side-effecting MMIO sees a single write.
                oMWriteEnable = write_q && (cnt_q == '0);
            end
            RESP: begin
                if (grant_q == GNT_I) begin
                    oIValid    = 1'b1;
                    oIReadData = rdata_q;
                end else if (grant_q == GNT_D) begin
                    oDValid    = 1'b1;
                    oDReadData = write_q ? 32'h0 : rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a read-data scoreboard.
// Contention expectations follow the ARB_RR_EN build macro.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        i_req, i_valid, d_req, d_write, d_valid;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, m_be;
    logic        m_re, m_we, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  grant, dbg_state;

    logic        sw_req;
    logic [31:0] sw_addr, sw_rdata;
    logic [31:0] cyc = 32'h0;
    logic [31:0] l1_irdata, l1_drdata, l1_maddr, l1_mwdata;
    logic [31:0] l15_irdata, l15_drdata, l15_maddr, l15_mwdata;
    logic        l1_ivalid, l1_dvalid, l1_re, l1_we, l1_busy;
    logic        l15_ivalid, l15_dvalid, l15_re, l15_we, l15_busy;
    logic [3:0]  l1_mbe, l15_mbe;
    logic [1:0]  l1_grant, l15_grant, l1_state, l15_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h0000_0013;
        return {a[15:0], 16'hC0DE} ^ {16'h0, a[31:16]};
    endfunction

    assign m_rdata  = mem_model(m_addr);
    assign sw_rdata = 32'hA500_0000 | cyc;
    always @(posedge clk) cyc <= cyc + 32'd1;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .CNT_W(4)) u_dut (
        .iCLK(clk), .iRST(rst_n),
        .iIReq(i_req), .iIAddress(i_addr), .oIReadData(i_rdata), .oIValid(i_valid),
        .iDReq(d_req), .iDWrite(d_write), .iDByteEnable(d_be), .iDAddress(d_addr),
        .iDWriteData(d_wdata), .oDReadData(d_rdata), .oDValid(d_valid),
        .oMReadEnable(m_re), .oMWriteEnable(m_we), .oMByteEnable(m_be),
        .oMAddress(m_addr), .oMWriteData(m_wdata), .iMReadData(m_rdata),
        .oGrant(grant), .oBusy(busy), .oDbgState(dbg_state)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_l1 (
        .iCLK(clk), .iRST(rst_n),
        .iIReq(1'b0), .iIAddress(32'h0), .oIReadData(l1_irdata), .oIValid(l1_ivalid),
        .iDReq(sw_req), .iDWrite(1'b0), .iDByteEnable(4'hF), .iDAddress(sw_addr),
        .iDWriteData(32'h0), .oDReadData(l1_drdata), .oDValid(l1_dvalid),
        .oMReadEnable(l1_re), .oMWriteEnable(l1_we), .oMByteEnable(l1_mbe),
        .oMAddress(l1_maddr), .oMWriteData(l1_mwdata), .iMReadData(sw_rdata),
        .oGrant(l1_grant), .oBusy(l1_busy), .oDbgState(l1_state)
    );

    mem_port_arbiter #(.MEM_LATENCY(15), .CNT_W(4)) u_l15 (
        .iCLK(clk), .iRST(rst_n),
        .iIReq(1'b0), .iIAddress(32'h0), .oIReadData(l15_irdata), .oIValid(l15_ivalid),
        .iDReq(sw_req), .iDWrite(1'b0), .iDByteEnable(4'hF), .iDAddress(sw_addr),
        .iDWriteData(32'h0), .oDReadData(l15_drdata), .oDValid(l15_dvalid),
        .oMReadEnable(l15_re), .oMWriteEnable(l15_we), .oMByteEnable(l15_mbe),
        .oMAddress(l15_maddr), .oMWriteData(l15_mwdata), .iMReadData(sw_rdata),
        .oGrant(l15_grant), .oBusy(l15_busy), .oDbgState(l15_state)
    );

    // scoreboard / checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit d_side, input int exp_lat, input string tag);
        int lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (d_side ? d_valid : i_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (lat > 0) pop_check({tag, "_data"}, d_side ? d_rdata : i_rdata);
    endtask

    // Valid pulses must be mutually exclusive and one cycle wide.
    logic prev_iv = 1'b0, prev_dv = 1'b0;
    always @(negedge clk) begin
        check("valid_exclusive", 32'(i_valid & d_valid), 32'd0);
        check("i_valid_single", 32'(prev_iv & i_valid), 32'd0);
        check("d_valid_single", 32'(prev_dv & d_valid), 32'd0);
        prev_iv = i_valid;
        prev_dv = d_valid;
    end

    logic [1:0]  exp_g[3];
    logic [31:0] c0;
    int          lat1, lat15;

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_write = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; sw_req = 1'b0; sw_addr = 32'h1000_0100;
        repeat (2) tick();
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_grant", 32'(grant), 32'(GNT_NONE));
        check("rst_outs", {26'd0, busy, m_re, m_we, i_valid, d_valid, |m_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // fetch only
        i_addr = 32'h0040_0000; i_req = 1'b1;
        exp_q.push_back(32'h0000_0013);
        tick();
        check("fetch_grant", 32'(grant), 32'(GNT_I));
        check("fetch_re1", 32'(m_re), 32'd1);
        check("fetch_we", 32'(m_we), 32'd0);
        check("fetch_addr", m_addr, 32'h0040_0000);
        check("fetch_be", 32'(m_be), 32'hF);
        tick();
        check("fetch_re2", 32'(m_re), 32'd1);
        check("fetch_early_valid", 32'(i_valid), 32'd0);
        tick();
        check("fetch_valid", 32'(i_valid), 32'd1);
        pop_check("fetch_data", i_rdata);
        check("fetch_resp_re", 32'(m_re), 32'd0);
        i_req = 1'b0;
        tick();
        check("fetch_grant_clr", 32'(grant), 32'(GNT_NONE));
        check("fetch_idle", 32'(busy), 32'd0);

        // store
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        exp_q.push_back(32'h0);
        tick();
        check("store_grant", 32'(grant), 32'(GNT_D));
        check("store_we1", 32'(m_we), 32'd1);
        check("store_re", 32'(m_re), 32'd0);
        check("store_addr", m_addr, 32'h1001_0004);
        check("store_wdata", m_wdata, 32'hDEAD_BEEF);
        check("store_be", 32'(m_be), 32'b0011);
        tick();
        check("store_we2", 32'(m_we), 32'd0);
        tick();
        check("store_valid", 32'(d_valid), 32'd1);
        pop_check("store_rdata", d_rdata);
        d_req = 1'b0; d_write = 1'b0;
        tick();

        // contention from a fresh reset so the round-robin history starts at instruction
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
`ifdef ARB_RR_EN
        exp_g = '{GNT_D, GNT_I, GNT_D};
`else
        exp_g = '{GNT_D, GNT_D, GNT_D};
`endif
        i_addr = 32'h0040_0004; d_addr = 32'h1001_0008; d_be = 4'hF;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mem_model(exp_g[k] == GNT_D ? d_addr : i_addr));
            tick();
            check($sformatf("cont_grant%0d", k), 32'(grant), 32'(exp_g[k]));
            repeat (LAT) tick();
            if (exp_g[k] == GNT_D) begin
                check($sformatf("cont_dvalid%0d", k), 32'(d_valid), 32'd1);
                pop_check($sformatf("cont_data%0d", k), d_rdata);
            end else begin
                check($sformatf("cont_ivalid%0d", k), 32'(i_valid), 32'd1);
                pop_check($sformatf("cont_data%0d", k), i_rdata);
            end
            tick();
            check($sformatf("cont_idle%0d", k), 32'(busy), 32'd0);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // reset in the second access cycle of a load
        d_addr = 32'h1001_0010; d_write = 1'b0; d_req = 1'b1;
        tick();
        tick();
        check("rmid_re", 32'(m_re), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rmid_state", 32'(dbg_state), 32'(IDLE));
        check("rmid_enables", {30'd0, m_re, m_we}, 32'd0);
        check("rmid_grant", 32'(grant), 32'(GNT_NONE));
        rst_n = 1'b1; d_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rmid_no_valid", 32'(d_valid), 32'd0);
        end

        // request withdrawn during the first access cycle
        i_addr = 32'h0040_0008; i_req = 1'b1;
        exp_q.push_back(mem_model(i_addr));
        tick();
        i_req = 1'b0;
        check("wd_grant", 32'(grant), 32'(GNT_I));
        wait_resp(1'b0, LAT, "wd");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wd_idle", {30'd0, busy, |grant}, 32'd0);
        end

        // latency sweep: MEM_LATENCY = 1 and 15
        c0 = cyc; sw_req = 1'b1; lat1 = -1; lat15 = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (l1_dvalid && lat1 < 0) begin
                lat1 = n;
                check("l1_data", l1_drdata, 32'hA500_0000 | (c0 + 32'd1));
            end
            if (l15_dvalid && lat15 < 0) begin
                lat15 = n;
                check("l15_data", l15_drdata, 32'hA500_0000 | (c0 + 32'd15));
            end
            if (lat1 > 0 && lat15 > 0) break;
        end
        check("l1_latency", lat1, 32'd2);
        check("l15_latency", lat15, 32'd16);
        sw_req = 1'b0;
        repeat (20) tick();
        check("sweep_idle", {30'd0, l1_busy, l15_busy}, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the CPU instruction-fetch bus and data bus (multicycle and pipeline builds with unified memory).
- Grants one requester at a time and drives the shared port for a fixed MEM_LATENCY access window.
- Returns read data or a write acknowledge to the granted requester with a one-cycle valid pulse.

Parameters:
MEM_LATENCY, 2, cycles the memory needs from address/enable to valid iMReadData (legal range 1..15)
CNT_W, 4, width of the access-window counter (must hold MEM_LATENCY-1)

Ports:
iCLK  input  1  system clock
iRST  input  1  reset, synchronous, active-low
iIReq  input  1  instruction fetch request (level, held until oIValid)
iIAddress  input  32  fetch address, stable while iIReq=1
oIReadData  output  32  fetched word, valid with oIValid
oIValid  output  1  one-cycle completion pulse, instruction side
iDReq  input  1  data request (level, held until oDValid)
iDWrite  input  1  1=store, 0=load
iDByteEnable  input  4  store byte lanes
iDAddress  input  32  data address
iDWriteData  input  32  store data
oDReadData  output  32  load word, valid with oDValid
oDValid  output  1  one-cycle completion pulse, data side (load data or store ack)
oMReadEnable  output  1  shared memory read enable
oMWriteEnable  output  1  shared memory write enable
oMByteEnable  output  4  shared memory byte lanes
oMAddress  output  32  shared memory address
oMWriteData  output  32  shared memory write data
iMReadData  input  32  shared memory read data
oGrant  output  2  00 none, 01 instruction, 10 data
oBusy  output  1  1 whenever state != IDLE

Behaviour:
- Reset: iCLK and iRST only; iRST=0 sampled at a rising edge resets the block (synchronous, active-low).
- Reset values: state IDLE, all outputs 0, oGrant=00, holding registers 0.
- FSM IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner's address, write flag, byte enables and write data into holding registers; set oGrant; clear counter; go to ACCESS.
- FSM ACCESS (exactly MEM_LATENCY cycles):
  - oMAddress, oMByteEnable and oMWriteData come from the holding registers.
  - Load/fetch: oMReadEnable=1 for every ACCESS cycle.
  - Store: oMWriteEnable=1 in the first ACCESS cycle only. No repeated writes to MMIO.
  - Last cycle (counter==MEM_LATENCY-1): capture iMReadData into the response register; go to RESP.
- FSM RESP (1 cycle):
  - Granted side's oXValid=1 and oXReadData=captured word. For a store, oDReadData=0.
  - Memory enables are 0.
  - Next state is IDLE.
- Latency: request seen in IDLE cycle t gives valid at t+MEM_LATENCY+1. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requesters may drop or re-raise req in the RESP cycle. The arbiter samples requests only in IDLE.
- Simultaneous iIReq and iDReq (no ARB_RR_EN): data wins. Instruction is served in the next IDLE if still requested.
- Requester drops req mid-access: the access completes and the valid pulse is still issued; the requester ignores it. A store is never cancelled.
- Inputs changing during ACCESS have no effect; the holding registers are used.
- Reset mid-ACCESS/RESP: return to IDLE next edge, enables 0, no valid pulse. Requesters reissue.
- oDValid and oIValid are never high in the same cycle. Neither is ever high for more than one consecutive cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant register (reset value = instruction) is updated on each grant.
  - On simultaneous requests, the side not granted last wins.
  - A single request is always granted immediately.
- Undefined: fixed priority, data over instruction. last_grant is not implemented.

Decomposition:
- Shared include/package holds:
  - State encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Grant encodings GNT_NONE/GNT_I/GNT_D.
  - Default MEM_LATENCY.
- One natural sub-module: arb_grant_select.
  - Combinational winner selection from iIReq, iDReq and last_grant.
  - Contains the ARB_RR_EN variants.
- FSM, counter and holding registers stay in the top.

Test Plan:
- Fetch only: iIReq=1, addr 0x0040_0000, memory returns 0x0000_0013 with MEM_LATENCY=2 -> oMReadEnable high 2 cycles, oIValid pulse at t+3, oIReadData=0x0000_0013, oGrant=01 then 00.
- Store: iDReq=1, iDWrite=1, addr 0x1001_0004, data 0xDEAD_BEEF, BE=4'b0011 -> oMWriteEnable exactly 1 cycle with those values, oDValid at t+3, oDReadData=0.
- Contention: both requests held for 3 transactions -> fixed priority: D, D, D with instruction starved while iDReq=1; with ARB_RR_EN: D, I, D.
- Reset mid-access: iRST=0 in 2nd ACCESS cycle of a load -> next cycle state IDLE, all enables 0, no oDValid ever for that load.
- Request withdrawn: iIReq dropped in 1st ACCESS cycle -> access completes, oIValid still pulses once, arbiter returns to IDLE and idles with no requests.
- MEM_LATENCY=1 and 15 sweep: valid observed exactly MEM_LATENCY+1 cycles after the IDLE grant cycle; captured data equals iMReadData in the last ACCESS cycle.
